// File: rtl/tile_vram_arbiter.sv
// Arbitrates one single-port synchronous tile VRAM between display reads
// (strict priority) and buffered game-logic writes. Writes wait in a small
// FIFO and drain in cycles without a display read; an optional stall limit
// forces a write slot, dropping that cycle's display read.
module tile_vram_arbiter #(
  parameter int unsigned AW           = 10,
  parameter int unsigned DW           = 12,
  parameter int unsigned WBUF_DEPTH   = 8,
  parameter int unsigned STARVE_LIMIT = 0
) (
  input  logic                          vga_clk,
  input  logic                          clrn,
  input  logic                          disp_req,
  input  logic [AW-1:0]                 disp_addr,
  output logic                          disp_rvalid,
  output logic [DW-1:0]                 disp_rdata,
  output logic                          disp_miss,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [DW-1:0]                 wr_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [AW-1:0]                 mem_addr,
  output logic [DW-1:0]                 mem_wdata,
  input  logic [DW-1:0]                 mem_rdata,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_level,
  output logic [15:0]                   miss_cnt
);

  localparam int unsigned PW = $clog2(WBUF_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] StallMax = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LevelFull = LW'(WBUF_DEPTH);

  logic [AW-1:0] buf_addr_q [WBUF_DEPTH];
  logic [DW-1:0] buf_data_q [WBUF_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          rvalid_q;
  logic [15:0]   miss_cnt_q;

  logic empty, push, pop, force_wr, disp_gnt;

  // Grant decision and VRAM port drive for the current cycle.
  always_comb begin
    empty    = (level_q == '0);
    wr_ready = (level_q != LevelFull);
    push     = wr_valid & wr_ready;
    // A limit of zero disables forcing entirely.
    force_wr = (STARVE_LIMIT > 0) && (stall_q == StallMax) && !empty;
    disp_gnt = disp_req & ~force_wr;
    pop      = force_wr | (~disp_req & ~empty);
    disp_miss = force_wr & disp_req;
    // Gate with reset so the VRAM sees no access while clrn is low.
    mem_en    = clrn & (force_wr | disp_req | ~empty);
    mem_we    = clrn & pop;
    mem_addr  = pop ? buf_addr_q[rd_ptr_q] : disp_addr;
    mem_wdata = buf_data_q[rd_ptr_q];
  end

  // Next-state for FIFO occupancy and the write-stall counter.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    stall_d = stall_q;
    if (empty || pop) begin
      stall_d = '0;
    end else if (stall_q != StallMax) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // FIFO storage; reset only clears pointers, stale entries are never read.
  always_ff @(posedge vga_clk) begin
    if (push) begin
      buf_addr_q[wr_ptr_q] <= wr_addr;
      buf_data_q[wr_ptr_q] <= wr_data;
    end
  end

  // Control state: pointers, level, stall, read-valid and miss counter.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      stall_q    <= '0;
      rvalid_q   <= 1'b0;
      miss_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q  <= level_d;
      stall_q  <= stall_d;
      rvalid_q <= disp_gnt;
      if (disp_miss && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign disp_rvalid = rvalid_q;
  assign disp_rdata  = mem_rdata;
  assign wbuf_level  = level_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_tile_vram_arbiter.sv
// Bench for tile_vram_arbiter: two instances (no forcing, and a stall limit
// of 4) each backed by a behavioural VRAM, checked every cycle against a
// queue-based reference model, plus vector tables and directed sequences.
module tb_tile_vram_arbiter;
  localparam int AW = 10;
  localparam int DW = 12;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clrn;
  logic [1:0]                disp_req, disp_rvalid, disp_miss;
  logic [1:0][AW-1:0]        disp_addr, wr_addr, mem_addr;
  logic [1:0][DW-1:0]        disp_rdata, wr_data, mem_wdata;
  logic [1:0]                wr_valid, wr_ready, mem_en, mem_we;
  logic [1:0][3:0]           wbuf_level;
  logic [1:0][15:0]          miss_cnt;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] vram [1024];
    logic [DW-1:0] rdata;
    tile_vram_arbiter #(
      .AW(AW), .DW(DW), .WBUF_DEPTH(DEPTH), .STARVE_LIMIT(g * 4)
    ) dut (
      .vga_clk(clk), .clrn(clrn),
      .disp_req(disp_req[g]), .disp_addr(disp_addr[g]),
      .disp_rvalid(disp_rvalid[g]), .disp_rdata(disp_rdata[g]), .disp_miss(disp_miss[g]),
      .wr_valid(wr_valid[g]), .wr_ready(wr_ready[g]),
      .wr_addr(wr_addr[g]), .wr_data(wr_data[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(rdata),
      .wbuf_level(wbuf_level[g]), .miss_cnt(miss_cnt[g])
    );
    // Single-port synchronous VRAM, one cycle read latency.
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) vram[mem_addr[g]] <= mem_wdata[g];
      if (mem_en[g] && !mem_we[g]) rdata <= vram[mem_addr[g]];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input int d, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s [dut%0d] got=%0h want=%0h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // Reference model: write queue as a circular array, shadow VRAM contents.
  int            m_cnt [2];
  int            m_head[2];
  int            m_stall[2];
  int            m_miss[2];
  bit            m_rv  [2];
  bit            m_rdv [2];
  logic [DW-1:0] m_rd  [2];
  logic [AW-1:0] m_qa  [2][DEPTH];
  logic [DW-1:0] m_qd  [2][DEPTH];
  logic [DW-1:0] shadow  [2][1024];
  bit            shadow_v[2][1024];
  bit            g_force[2];
  bit            g_pop  [2];

  function automatic int lim_of(input int d);
    return d * 4;
  endfunction

  task automatic model_reset(input int d);
    m_cnt[d] = 0; m_head[d] = 0; m_stall[d] = 0; m_miss[d] = 0; m_rv[d] = 0;
  endtask

  // Mid-cycle: derive expected outputs from the model and compare.
  task automatic settle();
    bit empty;
    int exp_addr;
    #4;
    for (int d = 0; d < 2; d++) begin
      if (!clrn) model_reset(d);
      empty = (m_cnt[d] == 0);
      g_force[d] = (lim_of(d) > 0) && (m_stall[d] == lim_of(d)) && !empty;
      g_pop[d] = g_force[d] || (!disp_req[d] && !empty);
      cmp("mem_en", d, mem_en[d], clrn && (g_force[d] || disp_req[d] || !empty));
      cmp("mem_we", d, mem_we[d], clrn && g_pop[d]);
      if (clrn && (g_force[d] || disp_req[d] || !empty)) begin
        exp_addr = g_pop[d] ? int'(m_qa[d][m_head[d]]) : int'(disp_addr[d]);
        cmp("mem_addr", d, mem_addr[d], exp_addr);
        if (g_pop[d]) cmp("mem_wdata", d, mem_wdata[d], m_qd[d][m_head[d]]);
      end
      cmp("disp_miss", d, disp_miss[d], g_force[d] && disp_req[d]);
      cmp("wr_ready", d, wr_ready[d], m_cnt[d] != DEPTH);
      cmp("wbuf_level", d, wbuf_level[d], m_cnt[d]);
      cmp("disp_rvalid", d, disp_rvalid[d], m_rv[d]);
      cmp("miss_cnt", d, miss_cnt[d], m_miss[d]);
      if (m_rv[d] && m_rdv[d]) cmp("disp_rdata", d, disp_rdata[d], m_rd[d]);
    end
  endtask

  // Apply this cycle's effects to the model, then move past the clock edge.
  task automatic advance();
    bit push, old_empty;
    int tail;
    for (int d = 0; d < 2; d++) begin
      if (clrn) begin
        old_empty = (m_cnt[d] == 0);
        push = wr_valid[d] && (m_cnt[d] != DEPTH);
        tail = (m_head[d] + m_cnt[d]) % DEPTH;
        m_rv[d] = disp_req[d] && !g_force[d];
        if (m_rv[d]) begin
          m_rd[d]  = shadow[d][disp_addr[d]];
          m_rdv[d] = shadow_v[d][disp_addr[d]];
        end
        if (g_force[d] && disp_req[d] && m_miss[d] < 65535) m_miss[d]++;
        if (g_pop[d]) begin
          shadow[d][m_qa[d][m_head[d]]]   = m_qd[d][m_head[d]];
          shadow_v[d][m_qa[d][m_head[d]]] = 1'b1;
          m_head[d] = (m_head[d] + 1) % DEPTH;
          m_cnt[d]--;
        end
        if (push) begin
          m_qa[d][tail] = wr_addr[d];
          m_qd[d][tail] = wr_data[d];
          m_cnt[d]++;
        end
        if (g_pop[d] || old_empty) m_stall[d] = 0;
        else if (m_stall[d] < lim_of(d)) m_stall[d]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle_all();
    disp_req = '0; disp_addr = '0; wr_valid = '0; wr_addr = '0; wr_data = '0;
  endtask

  typedef struct {
    bit            dreq;
    logic [AW-1:0] da;
    bit            wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    bit            en;
    bit            we;
    logic [AW-1:0] ma;
    logic [DW-1:0] mwd;
    int            lvl;
  } vec_t;

  vec_t tbl[7];
  int   reads, writes;

  initial begin
    tbl[0] = '{0, 0, 1, 0, 12'hA00, 0, 0, 0, 0,      0};
    tbl[1] = '{0, 0, 1, 1, 12'hA01, 1, 1, 0, 12'hA00, 1};
    tbl[2] = '{0, 0, 1, 2, 12'hA02, 1, 1, 1, 12'hA01, 1};
    tbl[3] = '{0, 0, 1, 3, 12'hA03, 1, 1, 2, 12'hA02, 1};
    tbl[4] = '{0, 0, 0, 0, 0,       1, 1, 3, 12'hA03, 1};
    tbl[5] = '{0, 0, 0, 0, 0,       0, 0, 0, 0,      0};
    tbl[6] = '{1, 3, 0, 0, 0,       1, 0, 3, 0,      0};
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      for (int a = 0; a < 1024; a++) shadow_v[d][a] = 1'b0;
    end
    idle_all();
    clrn = 1'b0;
    #1;
    tick();
    tick();
    clrn = 1'b1;
    tick();

    // Reset mid-traffic with three writes queued behind display reads.
    disp_req[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid[0] = 1'b1; wr_addr[0] = AW'(500 + i); wr_data[0] = DW'(i + 1);
      tick();
    end
    wr_valid[0] = 1'b0;
    clrn = 1'b0;
    settle();
    cmp("rst_level", 0, wbuf_level[0], 0);
    cmp("rst_ready", 0, wr_ready[0], 1);
    cmp("rst_en", 0, mem_en[0], 0);
    advance();
    clrn = 1'b1;
    disp_req[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      cmp("post_rst_no_we", 0, mem_we[0], 0);
      advance();
    end

    // Vector table: writes drain in order with no display traffic.
    foreach (tbl[i]) begin
      disp_req[0] = tbl[i].dreq; disp_addr[0] = tbl[i].da;
      wr_valid[0] = tbl[i].wv; wr_addr[0] = tbl[i].wa; wr_data[0] = tbl[i].wd;
      settle();
      cmp($sformatf("vec%0d_en", i), 0, mem_en[0], tbl[i].en);
      if (tbl[i].en) begin
        cmp($sformatf("vec%0d_we", i), 0, mem_we[0], tbl[i].we);
        cmp($sformatf("vec%0d_addr", i), 0, mem_addr[0], tbl[i].ma);
        if (tbl[i].we) cmp($sformatf("vec%0d_wdata", i), 0, mem_wdata[0], tbl[i].mwd);
      end
      cmp($sformatf("vec%0d_level", i), 0, wbuf_level[0], tbl[i].lvl);
      advance();
    end
    idle_all();
    tick();

    // Display priority: 10 reads, two queued writes wait until reads stop.
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      disp_req[0] = 1'b1; disp_addr[0] = AW'(100 + i);
      wr_valid[0] = (i < 2); wr_addr[0] = AW'(200 + i); wr_data[0] = DW'(i + 7);
      settle();
      if (mem_en[0] && !mem_we[0]) reads++;
      cmp("prio_no_write", 0, mem_we[0], 0);
      if (i > 0) cmp("prio_rvalid", 0, disp_rvalid[0], 1);
      advance();
    end
    cmp("prio_reads", 0, reads, 10);
    idle_all();
    writes = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      if (i == 0) cmp("prio_last_rvalid", 0, disp_rvalid[0], 1);
      if (mem_we[0]) writes++;
      advance();
    end
    cmp("prio_drained", 0, writes, 2);

    // Full FIFO: eight accepted, ninth refused, then drain one per cycle.
    disp_req[0] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_valid[0] = 1'b1; wr_addr[0] = AW'(300 + i); wr_data[0] = DW'(12'h300 + i);
      settle();
      if (i == 8) begin
        cmp("full_ready", 0, wr_ready[0], 0);
        cmp("full_level", 0, wbuf_level[0], 8);
      end
      advance();
    end
    wr_valid[0] = 1'b0;
    settle();
    cmp("full_no_9th", 0, wbuf_level[0], 8);
    advance();
    disp_req[0] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      settle();
      cmp("drain_level", 0, wbuf_level[0], 8 - k);
      advance();
    end

    // Starvation on the limit-4 instance: forced write on the 5th stalled cycle.
    disp_req[1] = 1'b1; disp_addr[1] = AW'(5);
    wr_valid[1] = 1'b1; wr_addr[1] = AW'(400); wr_data[1] = 12'h123;
    for (int i = 0; i < 7; i++) begin
      settle();
      if (i >= 1 && i <= 4) begin
        cmp("starve_wait_we", 1, mem_we[1], 0);
        cmp("starve_wait_miss", 1, disp_miss[1], 0);
      end
      if (i == 5) begin
        cmp("starve_force_we", 1, mem_we[1], 1);
        cmp("starve_miss", 1, disp_miss[1], 1);
      end
      if (i == 6) begin
        cmp("starve_no_rvalid", 1, disp_rvalid[1], 0);
        cmp("starve_miss_cnt", 1, miss_cnt[1], 1);
        cmp("starve_miss_once", 1, disp_miss[1], 0);
      end
      advance();
      wr_valid[1] = 1'b0;
    end
    idle_all();
    tick();

    // Readback through the VRAM after the write has retired.
    wr_valid[0] = 1'b1; wr_addr[0] = AW'(37); wr_data[0] = 12'h5F3;
    tick();
    wr_valid[0] = 1'b0;
    tick();
    disp_req[0] = 1'b1; disp_addr[0] = AW'(37);
    tick();
    disp_req[0] = 1'b0;
    settle();
    cmp("readback_rvalid", 0, disp_rvalid[0], 1);
    cmp("readback_rdata", 0, disp_rdata[0], 12'h5F3);
    advance();

    // Random traffic on both instances with occasional resets.
    for (int n = 0; n < 600; n++) begin
      for (int d = 0; d < 2; d++) begin
        disp_req[d]  = ($urandom_range(9) < 7);
        disp_addr[d] = AW'($urandom_range(15));
        wr_valid[d]  = $urandom_range(1) == 1;
        wr_addr[d]   = AW'($urandom_range(15));
        wr_data[d]   = DW'($urandom);
      end
      clrn = ($urandom_range(299) != 0);
      tick();
    end
    clrn = 1'b1;
    idle_all();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
